// File: rtl/cu_seq.sv
// Multi-cycle control-unit sequencer: accepts one opcode at a time, steps it through
// DECODE/EXEC/(MEM)/WB and drives datapath controls as a Moore function of state and op_q.
module cu_seq #(
  parameter int OP_W      = 6,
  parameter int ALU_SEL_W = 4,
  parameter int SRC_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 alu_c_in,
  output logic                 alu_enable,
  output logic                 reg_read_a,
  output logic                 reg_read_b,
  output logic                 reg_write,
  output logic                 reg_reset,
  output logic                 mem_we,
  output logic [1:0]           inst_type,
  output logic [SRC_SEL_W-1:0] src_sel,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 pc_inc,
  output logic                 illegal,
  output logic                 halted,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  // Decoded fields of the latched opcode
  logic [7:0] op8;
  logic [3:0] dec_alu;
  logic [2:0] dec_src;
  logic [1:0] dec_type;
  logic       r_type, dec_ra, dec_rb, dec_wr, dec_aen;
  logic       dec_mem, dec_store, dec_halt, dec_rst, dec_ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Zero-extend so that any set bit above bit 5 falls through to the illegal default
  assign op8 = 8'(op_q);

  always_comb begin
    dec_alu   = 4'b0000;
    dec_src   = 3'b000;
    dec_type  = 2'b00;
    r_type    = 1'b0;
    dec_ra    = 1'b0;
    dec_rb    = 1'b0;
    dec_wr    = 1'b0;
    dec_aen   = 1'b0;
    dec_mem   = 1'b0;
    dec_store = 1'b0;
    dec_halt  = 1'b0;
    dec_rst   = 1'b0;
    dec_ill   = 1'b0;
    case (op8)
      8'h00: ;
      8'h01: begin r_type = 1'b1; dec_alu = 4'b0000; end
      8'h02: begin r_type = 1'b1; dec_alu = 4'b0001; end
      8'h03: begin r_type = 1'b1; dec_alu = 4'b0010; end
      8'h04: begin r_type = 1'b1; dec_alu = 4'b0011; end
      8'h05: begin r_type = 1'b1; dec_alu = 4'b0100; end
      8'h06: begin r_type = 1'b1; dec_alu = 4'b0101; end
      8'h07: begin r_type = 1'b1; dec_alu = 4'b0110; end
      8'h08: begin r_type = 1'b1; dec_alu = 4'b0111; end
      8'h09: begin r_type = 1'b1; dec_alu = 4'b1100; end
      8'h0A: begin r_type = 1'b1; dec_alu = 4'b1001; end
      8'h0B: begin r_type = 1'b1; dec_alu = 4'b1000; end
      8'h0C: begin r_type = 1'b1; dec_alu = 4'b1010; end
      8'h0D: begin r_type = 1'b1; dec_alu = 4'b1011; end
      8'h0E: begin
        dec_alu = 4'b0010; dec_src = 3'b001; dec_type = 2'b10;
        dec_wr  = 1'b1;    dec_aen = 1'b1;
      end
      8'h0F: begin
        dec_src = 3'b001; dec_type = 2'b10;
        dec_ra  = 1'b1;   dec_wr   = 1'b1; dec_aen = 1'b1;
      end
      8'h10: begin
        dec_src = 3'b010; dec_type = 2'b11; dec_ra  = 1'b1;
        dec_wr  = 1'b1;   dec_aen  = 1'b1;  dec_mem = 1'b1;
      end
      8'h11: begin
        dec_src = 3'b010; dec_type = 2'b11; dec_ra    = 1'b1; dec_rb = 1'b1;
        dec_aen = 1'b1;   dec_mem  = 1'b1;  dec_store = 1'b1;
      end
      8'h12: dec_halt = 1'b1;
      8'h13: dec_rst  = 1'b1;
      default: dec_ill = 1'b1;
    endcase
    if (r_type) begin
      dec_type = 2'b01;
      dec_ra   = 1'b1;
      dec_rb   = (op8 != 8'h09);  // INV has a single source operand
      dec_wr   = 1'b1;
      dec_aen  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_mem)       state_d = S_MEM;
        else if (dec_halt) state_d = S_HALT;
        else               state_d = S_WB;
      end
      S_MEM:  if (mem_ack) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    alu_c_in    = 1'b0;
    alu_enable  = 1'b0;
    reg_read_a  = 1'b0;
    reg_read_b  = 1'b0;
    reg_write   = 1'b0;
    reg_reset   = 1'b0;
    pc_inc      = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    busy        = 1'b0;
    inst_type   = 2'b00;
    src_sel     = '0;
    alu_sel     = '0;
    case (state_q)
      S_IDLE: instr_ready = 1'b1;
      S_HALT: halted      = 1'b1;
      S_DECODE, S_EXEC, S_MEM, S_WB: begin
        // Decoded selects and register reads stay stable for the whole instruction
        busy       = 1'b1;
        inst_type  = dec_type;
        src_sel    = SRC_SEL_W'(dec_src);
        alu_sel    = ALU_SEL_W'(dec_alu);
        reg_read_a = dec_ra;
        reg_read_b = dec_rb;
        case (state_q)
          S_DECODE: illegal = dec_ill;
          S_EXEC:   alu_enable = dec_aen;
          S_MEM: begin
            mem_req    = 1'b1;
            mem_we     = dec_store;
            alu_enable = 1'b1;
          end
          default: begin
            reg_write = dec_wr;
            reg_reset = dec_rst;
            pc_inc    = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_seq.sv
// Scoreboard bench for cu_seq: per instruction, the expected output vector of every
// cycle is queued from a table model, then popped and compared on each falling edge.
module tb_cu_seq;
  localparam int OP_W      = 6;
  localparam int ALU_SEL_W = 4;
  localparam int SRC_SEL_W = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [OP_W-1:0]      opcode;
  logic                 instr_valid, instr_ready;
  logic                 mem_req, mem_ack;
  logic                 alu_c_in, alu_enable, reg_read_a, reg_read_b;
  logic                 reg_write, reg_reset, mem_we;
  logic [1:0]           inst_type;
  logic [SRC_SEL_W-1:0] src_sel;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 pc_inc, illegal, halted, busy;

  typedef struct packed {
    logic       instr_ready;
    logic       mem_req;
    logic       mem_we;
    logic       alu_c_in;
    logic       alu_enable;
    logic       reg_read_a;
    logic       reg_read_b;
    logic       reg_write;
    logic       reg_reset;
    logic       pc_inc;
    logic       illegal;
    logic       halted;
    logic       busy;
    logic [1:0] inst_type;
    logic [2:0] src_sel;
    logic [3:0] alu_sel;
  } outs_t;

  typedef struct {
    outs_t exp;
    bit    vld;
    bit    ack;
    int    cyc;
  } item_t;

  outs_t obs;
  outs_t idle_v;
  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {instr_ready, mem_req, mem_we, alu_c_in, alu_enable, reg_read_a,
                reg_read_b, reg_write, reg_reset, pc_inc, illegal, halted, busy,
                inst_type, src_sel, alu_sel};

  cu_seq #(.OP_W(OP_W), .ALU_SEL_W(ALU_SEL_W), .SRC_SEL_W(SRC_SEL_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_req(mem_req), .mem_ack(mem_ack),
    .alu_c_in(alu_c_in), .alu_enable(alu_enable), .reg_read_a(reg_read_a),
    .reg_read_b(reg_read_b), .reg_write(reg_write), .reg_reset(reg_reset),
    .mem_we(mem_we), .inst_type(inst_type), .src_sel(src_sel), .alu_sel(alu_sel),
    .pc_inc(pc_inc), .illegal(illegal), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Decode table: flags f = {ra, rb, wr, alu_en, mem, store, halt, rst, illegal}
  function automatic void dec_model(input logic [7:0] op, output logic [3:0] a,
                                    output logic [2:0] s, output logic [1:0] t,
                                    output logic [8:0] f);
    a = 4'b0000; s = 3'b000; t = 2'b00; f = 9'b000000000;
    case (op)
      8'h01: begin a = 4'b0000; t = 2'b01; f = 9'b111100000; end
      8'h02: begin a = 4'b0001; t = 2'b01; f = 9'b111100000; end
      8'h03: begin a = 4'b0010; t = 2'b01; f = 9'b111100000; end
      8'h04: begin a = 4'b0011; t = 2'b01; f = 9'b111100000; end
      8'h05: begin a = 4'b0100; t = 2'b01; f = 9'b111100000; end
      8'h06: begin a = 4'b0101; t = 2'b01; f = 9'b111100000; end
      8'h07: begin a = 4'b0110; t = 2'b01; f = 9'b111100000; end
      8'h08: begin a = 4'b0111; t = 2'b01; f = 9'b111100000; end
      8'h09: begin a = 4'b1100; t = 2'b01; f = 9'b101100000; end
      8'h0A: begin a = 4'b1001; t = 2'b01; f = 9'b111100000; end
      8'h0B: begin a = 4'b1000; t = 2'b01; f = 9'b111100000; end
      8'h0C: begin a = 4'b1010; t = 2'b01; f = 9'b111100000; end
      8'h0D: begin a = 4'b1011; t = 2'b01; f = 9'b111100000; end
      8'h0E: begin a = 4'b0010; s = 3'b001; t = 2'b10; f = 9'b001100000; end
      8'h0F: begin a = 4'b0000; s = 3'b001; t = 2'b10; f = 9'b101100000; end
      8'h10: begin a = 4'b0000; s = 3'b010; t = 2'b11; f = 9'b101110000; end
      8'h11: begin a = 4'b0000; s = 3'b010; t = 2'b11; f = 9'b110111000; end
      8'h12: f = 9'b000000100;
      8'h13: f = 9'b000000010;
      8'h00: f = 9'b000000000;
      default: f = 9'b000000001;
    endcase
  endfunction

  function automatic void push(input outs_t e, input bit v, input bit a);
    item_t it;
    it.exp = e;
    it.vld = v;
    it.ack = a;
    it.cyc = sb.size() + 1;
    sb.push_back(it);
  endfunction

  // k = cycles between MEM entry and mem_ack; noise drives instr_valid/mem_ack where ignored
  function automatic void push_instr(input logic [7:0] op, input int k, input bit noise);
    logic [3:0] a;
    logic [2:0] s;
    logic [1:0] t;
    logic [8:0] f;
    outs_t b, e;
    dec_model(op, a, s, t, f);
    b = '0;
    b.busy = 1'b1; b.inst_type = t; b.src_sel = s; b.alu_sel = a;
    b.reg_read_a = f[8]; b.reg_read_b = f[7];
    e = b; e.illegal = f[0];
    push(e, noise, noise);
    e = b; e.alu_enable = f[5];
    push(e, noise, noise);
    if (f[2]) begin
      for (int i = 0; i < 20; i++) begin
        e = '0; e.halted = 1'b1;
        push(e, noise, noise);
      end
      return;
    end
    if (f[4]) begin
      for (int j = 0; j <= k; j++) begin
        e = b; e.mem_req = 1'b1; e.mem_we = f[3]; e.alu_enable = 1'b1;
        push(e, noise, j == k);
      end
    end
    e = b; e.reg_write = f[6]; e.reg_reset = f[1]; e.pc_inc = 1'b1;
    push(e, noise, noise);
    e = '0; e.instr_ready = 1'b1;
    push(e, 1'b0, 1'b0);
  endfunction

  // Called at a falling edge while IDLE; returns at a falling edge
  task automatic run_instr(input string name, input logic [7:0] op, input int k, input bit noise);
    item_t it;
    push_instr(op, k, noise);
    instr_valid = 1'b1;
    opcode      = OP_W'(op);
    @(posedge clk);
    while (sb.size() > 0) begin
      @(negedge clk);
      it = sb.pop_front();
      checks++;
      if (obs !== it.exp) begin
        errors++;
        $display("FAIL %s op=%h cycle %0d: got %h expected %h", name, op, it.cyc, obs, it.exp);
      end
      instr_valid = it.vld;
      mem_ack     = it.ack;
      opcode      = OP_W'($urandom);
    end
    $display("txn %s op=%h k=%0d done, errors so far %0d", name, op, k, errors);
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; opcode = OP_W'(8'h01); mem_ack = 1'b1;
    #1;
    checks++;
    if (obs !== idle_v) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, idle_v);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== idle_v) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, idle_v);
    end
    rst = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== idle_v) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, idle_v);
    end
    $display("txn reset done, errors so far %0d", errors);
  endtask

  task automatic test_add();
    run_instr("add", 8'h01, 0, 1'b1);
  endtask

  task automatic test_ldim_inv();
    run_instr("ldim", 8'h0E, 0, 1'b0);
    run_instr("inv", 8'h09, 0, 1'b1);
  endtask

  task automatic test_memory();
    run_instr("store_k3", 8'h11, 3, 1'b1);
    run_instr("load_k0", 8'h10, 0, 1'b0);
    run_instr("load_k2", 8'h10, 2, 1'b1);
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 8'h3F, 0, 1'b1);
    run_instr("illegal_14", 8'h14, 0, 1'b0);
    run_instr("illegal_2a", 8'h2A, 0, 1'b1);
  endtask

  task automatic test_all_ops();
    for (int op = 0; op <= 8'h13; op++) begin
      if (op != 8'h12)
        run_instr("sweep", 8'(op), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_sub", 8'h02, 0, 1'b0);
    run_instr("b2b_xor", 8'h05, 0, 1'b0);
    run_instr("b2b_addi", 8'h0F, 0, 1'b1);
  endtask

  task automatic test_halt();
    run_instr("halt", 8'h12, 0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== idle_v) begin
      errors++;
      $display("FAIL halt_reset_exit: got %h expected %h", obs, idle_v);
    end
    @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    $display("txn halt_reset done, errors so far %0d", errors);
  endtask

  task automatic test_reset_mid_mem();
    instr_valid = 1'b1;
    opcode      = OP_W'(8'h10);
    @(posedge clk);
    @(negedge clk);                // DECODE
    instr_valid = 1'b0;
    @(negedge clk);                // EXEC
    @(negedge clk);                // MEM, first cycle
    @(negedge clk);                // MEM, still waiting
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_wait: got mem_req=%b busy=%b expected 1 1", mem_req, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== idle_v) begin
      errors++;
      $display("FAIL mid_mem_reset: got %h expected %h", obs, idle_v);
    end
    @(negedge clk);
    rst = 1'b0;
    // Accept on the very edge at which reset release takes effect
    run_instr("add_after_rst", 8'h01, 0, 1'b0);
  endtask

  initial begin
    idle_v = '0;
    idle_v.instr_ready = 1'b1;
    test_reset();
    test_add();
    test_ldim_inv();
    test_memory();
    test_illegal();
    test_all_ops();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 Parameter OP_W, default 6, opcode width; values 6..8 supported, upper bits above bit 5 must be zero for legal opcodes.
REQ-002 Parameter ALU_SEL_W, default 4, width of alu_sel.
REQ-003 Parameter SRC_SEL_W, default 3, width of src_sel.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 opcode  input  OP_W  instruction opcode, sampled only on accept.
REQ-007 instr_valid / instr_ready  input / output  1  instruction handshake; accept = both high on a clock edge.
REQ-008 mem_req / mem_ack  output / input  1  data-memory handshake for LOAD/STORE.
REQ-009 alu_c_in, alu_enable, reg_read_a, reg_read_b, reg_write, reg_reset, mem_we  output  1  datapath controls.
REQ-010 inst_type  output  2  (00 none, 01 R-type, 10 I-type, 11 memory).
REQ-011 src_sel  output  SRC_SEL_W ; alu_sel  output  ALU_SEL_W.
REQ-012 pc_inc, illegal  output  1  one-cycle pulses; halted, busy  output  1  levels.

Function
REQ-013 FSM states: IDLE, DECODE, EXEC, MEM, WB, HALT; encoding free.
REQ-014 IDLE: instr_ready=1, all other outputs 0; on accept latch opcode into op_q, go DECODE.
REQ-015 DECODE (1 cycle): reg_read_a/reg_read_b per table from op_q; inst_type, src_sel, alu_sel valid; go EXEC.
REQ-016 EXEC (1 cycle): alu_enable per table, reads held; memory ops go MEM, HALT op goes HALT, others go WB.
REQ-017 MEM: mem_req=1, mem_we=1 for STORE only, alu_enable=1 (address add); stay until mem_ack=1, then WB; no timeout.
REQ-018 WB (1 cycle): reg_write per table, reg_reset=1 for RST op, pc_inc=1; go IDLE.
REQ-019 Decode table (opcode: alu_sel, src_sel, type, ra, rb, wr): 01 ADD 0000; 02 SUB 0001; 03 OR 0010; 04 AND 0011; 05 XOR 0100; 06 NOR 0101; 07 NAND 0110; 08 XNOR 0111; 0A BSHL 1001; 0B BSHR 1000; 0C SBSHL 1010; 0D SBSHR 1011 -- all src 000, type 01, ra=rb=wr=1.
REQ-020 09 INV: alu_sel 1100, src 000, type 01, ra=1, rb=0, wr=1.
REQ-021 0E LDIM: alu_sel 0010, src 001, type 10, ra=0, rb=0, wr=1; 0F ADDI: alu_sel 0000, src 001, type 10, ra=1, rb=0, wr=1.
REQ-022 10 LOAD: alu_sel 0000, src 010, type 11, ra=1, rb=0, wr=1; 11 STORE: same but rb=1, wr=0, mem_we=1.
REQ-023 12 HALT: no datapath controls; 13 RST: reg_reset=1 in WB, wr=0; 00 NOP: DECODE/EXEC/WB with all controls 0, pc_inc=1.
REQ-024 Any other opcode: illegal=1 for the DECODE cycle, then treated exactly as NOP (pc_inc in WB).
REQ-025 alu_c_in=0 for all opcodes; alu_sel/src_sel zero-extended to parameter width.
REQ-026 HALT state: halted=1, instr_ready=0, all controls 0; left only by reset.
REQ-027 busy=1 in every state except IDLE and HALT.
REQ-028 Latency: non-memory op accepted at edge N -> DECODE N+1, EXEC N+2, WB N+3, instr_ready high again N+4; memory op adds k+1 cycles for mem_ack arriving k cycles after MEM entry.
REQ-029 instr_valid outside IDLE is ignored; opcode changes after accept have no effect.
REQ-030 mem_ack outside MEM is ignored.

Reset
REQ-031 rst high -> state IDLE, op_q=0, all outputs 0 except instr_ready=1, effective immediately (asynchronous), including mid-MEM (mem_req drops without waiting for mem_ack).
REQ-032 Release of rst takes effect on the next rising clk; first accept possible that edge.

Verification
REQ-033 ADD (01) accepted edge 0 -> reg_read_a=reg_read_b=1 cycles 1-3, alu_enable=1 cycle 2, alu_sel=0000, reg_write=1 and pc_inc=1 cycle 3 only, instr_ready=1 cycle 4.
REQ-034 LDIM (0E) -> src_sel=001, inst_type=10, reg_read_a=0, reg_write=1 in WB; INV (09) -> alu_sel=1100, reg_read_b=0.
REQ-035 STORE (11), mem_ack delayed 3 cycles -> mem_req=1, mem_we=1 for 4 cycles, then WB with reg_write=0, pc_inc=1.
REQ-036 Opcode 3F -> illegal pulse in DECODE, no write, pc_inc=1 in WB; HALT (12) -> halted=1, instr_ready=0 held for 20 cycles despite instr_valid=1.
REQ-037 rst asserted mid-MEM between clock edges -> mem_req, busy drop immediately; instr_ready=1; next ADD completes normally.
